reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//  Write-side front end of the 4-entry register file. Collects results from the
//  ALU and from the memory-load path, queues them in order, and drives the
//  file's write/wnum/wdata port with at most one write per cycle.
//  Keeps a per-register pending scoreboard for hazard detection, and provides a
//  forwarding lookup of the youngest queued value.
// PARAMETERS
//  WIDTH  32  data width; must match the register file WIDTH
//  NREGS  4   number of architectural registers; r0 is hard-wired 0
//  DEPTH  4   queue entries, power of 2, >=2
//  (local) AW=$clog2(NREGS), PW=$clog2(DEPTH), CW=$clog2(DEPTH+2)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  alu_valid  in   1      ALU result offered
//  alu_ready  out  1      ALU result accepted this edge when valid&ready
//  alu_num    in   AW     ALU destination register
//  alu_data   in   WIDTH  ALU result
//  mem_valid  in   1      load result offered
//  mem_ready  out  1      load result accepted this edge when valid&ready
//  mem_num    in   AW     load destination register
//  mem_data   in   WIDTH  load result
//  hold       in   1      1 = do not issue a new register-file write
//  write      out  1      register-file write enable (registered)
//  wnum       out  AW     register-file write address (registered)
//  wdata      out  WIDTH  register-file write data (registered)
//  pending    out  NREGS  bit i = a write to ri is queued or being issued
//  qnum       in   AW     forwarding query register
//  qhit       out  1      qnum has a queued or issuing value (comb.)
//  qdata      out  WIDTH  youngest such value; 0 when qhit=0 (comb.)
//  idle       out  1      queue empty and write=0
// BEHAVIOUR
//  Reset: queue empty, pointers 0, all counters 0; write=0, wnum=0, wdata=0,
//   pending=0, idle=1. Reset mid-operation discards all queued and issuing entries.
//  Accept (one per cycle):
//   - mem_ready = !full.
//   - alu_ready = !full & !mem_valid. Fixed priority: mem over alu.
//   - full = (queue count == DEPTH). Ready depends neither on a same-cycle pop
//     nor on the entry retiring in the issue stage.
//  Destination r0: the handshake completes, but nothing is enqueued. No write,
//   no pending change.
//  Queue: circular FIFO; rd/wr pointers wrap DEPTH-1 -> 0. Push and pop in the
//   same cycle are legal at any occupancy.
//  Issue, at each edge:
//   - write <= !hold & !empty.
//   - If !hold & !empty: {wnum,wdata} <= head, then pop. Otherwise wnum and
//     wdata hold their values.
//   - write is a 1-cycle pulse per entry; the register file captures at the next
//     edge. Back-to-back entries give consecutive write=1 cycles.
//   - hold never cancels a write already at 1.
//  Latency: accepted at edge k into an empty queue with hold=0 -> write=1 in the
//   cycle after edge k+1 -> the file captures at edge k+2.
//  Order: file writes occur in acceptance order. A later write to the same
//   register wins.
//  Scoreboard:
//   - cnt[i] (CW bits) +1 on an accepted entry to ri.
//   - cnt[i] -1 at each edge where write=1 and wnum=i (retire).
//   - Both events in the same cycle on the same i: unchanged.
//   - pending[i] = (cnt[i]!=0). pending[0] is always 0.
//  Forwarding:
//   - Search order: queue entries youngest->oldest, then the issue stage if
//     write=1.
//   - The first entry whose register equals qnum supplies qdata, with qhit=1.
//   - qnum=0 gives qhit=0 and qdata=0.
//   - Same-cycle incoming alu/mem data is not forwarded.
//  idle = (queue count==0) & !write.
// TESTING
//  1 rst, then alu r2=32'hDEADBEEF at edge k -> write=1, wnum=2 only in the
//    cycle after k+1; pending[2]=1 from k until the retire edge k+2.
//  2 alu r1=1 and mem r3=3 valid together -> alu_ready=0; writes are r3 then r1
//    on consecutive cycles.
//  3 hold=1, push 4 entries -> mem_ready=alu_ready=0, write=0. Release hold ->
//    4 consecutive writes in order; pointer wrap, then 2 more entries in order.
//  4 mem r0=32'h55 -> accepted; no write pulse; pending=0; idle stays 1.
//  5 hold=1, push r2=5 then r2=7 -> cnt[2]=2, qnum=2 gives qhit=1, qdata=7.
//    Release -> writes 5 then 7; pending[2] drops after the second write.
//  6 hold=1, push 3 entries, assert rst -> write=0, pending=0, idle=1; then a
//    new entry issues normally.

Source files
------------

// File: rtl/reg_writeback_if.sv
// reg_writeback_if
//  Bundles the producer handshakes (ALU and load results), the issue-control
//  input, the register-file write port, the pending scoreboard and the
//  forwarding lookup of reg_writeback into one port.
//  Ports / signals:
//   alu_valid/alu_ready/alu_num/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_num/mem_data   load result handshake
//   hold                                   suppress new register-file writes
//   write/wnum/wdata                       registered register-file write port
//   pending                                per-register write-outstanding flags
//   qnum/qhit/qdata                        forwarding query and answer
//   idle                                   nothing queued and nothing issuing
//  Modports: slave = the writeback block, master = whoever drives it.
interface reg_writeback_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 4
);
    localparam int AW = $clog2(NREGS);

    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_num;
    logic [WIDTH-1:0] alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [AW-1:0]    mem_num;
    logic [WIDTH-1:0] mem_data;
    logic             hold;
    logic             write;
    logic [AW-1:0]    wnum;
    logic [WIDTH-1:0] wdata;
    logic [NREGS-1:0] pending;
    logic [AW-1:0]    qnum;
    logic             qhit;
    logic [WIDTH-1:0] qdata;
    logic             idle;

    modport slave (
        input  alu_valid, alu_num, alu_data, mem_valid, mem_num, mem_data, hold, qnum,
        output alu_ready, mem_ready, write, wnum, wdata, pending, qhit, qdata, idle
    );

    modport master (
        output alu_valid, alu_num, alu_data, mem_valid, mem_num, mem_data, hold, qnum,
        input  alu_ready, mem_ready, write, wnum, wdata, pending, qhit, qdata, idle
    );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback
//  Write-side front end of the register file. Accepts ALU and load results
//  (load has priority), queues them in acceptance order and issues at most one
//  registered register-file write per cycle. Keeps a per-register count of
//  outstanding writes (queued or issuing) and answers forwarding queries with
//  the youngest outstanding value for a register. r0 is hard-wired zero, so
//  results addressed to it are accepted and dropped.
//  Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   reg_writeback_if slave modport (handshakes, write port, scoreboard,
//         forwarding lookup, idle). Interface WIDTH/NREGS must match the
//         parameters given here.
module reg_writeback #(
    parameter int WIDTH = 32,
    parameter int NREGS = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    reg_writeback_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);

    logic [AW-1:0]    q_num  [DEPTH];
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    cnt    [NREGS];

    logic             full;
    logic             empty;
    logic             acc_mem;
    logic             acc_alu;
    logic             push;
    logic             pop;
    logic [AW-1:0]    in_num;
    logic [WIDTH-1:0] in_data;

    // Ready is based on occupancy alone, never on a same-cycle pop.
    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign bus.mem_ready = !full;
    assign bus.alu_ready = !full && !bus.mem_valid;

    assign acc_mem = bus.mem_valid && !full;
    assign acc_alu = bus.alu_valid && bus.alu_ready;
    assign in_num  = acc_mem ? bus.mem_num  : bus.alu_num;
    assign in_data = acc_mem ? bus.mem_data : bus.alu_data;

    // r0 writes complete the handshake but never occupy the queue.
    assign push = (acc_mem || acc_alu) && (in_num != '0);
    assign pop  = !bus.hold && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            bus.write <= 1'b0;
            bus.wnum  <= '0;
            bus.wdata <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count + CW'(push) - CW'(pop);
            bus.write <= pop;
            if (pop) begin
                bus.wnum  <= q_num[rd_ptr];
                bus.wdata <= q_data[rd_ptr];
            end
        end
    end

    // Storage is only read behind the occupancy count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_num[wr_ptr]  <= in_num;
            q_data[wr_ptr] <= in_data;
        end
    end

    // An entry stays pending until the edge that retires its issued write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                cnt[i] <= cnt[i]
                        + CW'(push && (in_num == AW'(i)))
                        - CW'(bus.write && (bus.wnum == AW'(i)));
            end
        end
    end

    always_comb begin
        bus.pending = '0;
        for (int i = 1; i < NREGS; i++) bus.pending[i] = (cnt[i] != '0);
    end

    // Oldest first so that younger matches overwrite older ones; the issue
    // stage is older than anything still in the queue.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        bus.qhit  = 1'b0;
        bus.qdata = '0;
        if (bus.write && (bus.wnum == bus.qnum)) begin
            bus.qhit  = 1'b1;
            bus.qdata = bus.wdata;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (q_num[idx] == bus.qnum)) begin
                bus.qhit  = 1'b1;
                bus.qdata = q_data[idx];
            end
        end
        if (bus.qnum == '0) begin
            bus.qhit  = 1'b0;
            bus.qdata = '0;
        end
    end

    assign bus.idle = empty && !bus.write;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback
//  Bench for reg_writeback: a table of hand-computed vectors after reset, a few
//  directed multi-cycle sequences, then random traffic compared each cycle with
//  a queue-based reference model. Prints one summary line.
module tb_reg_writeback;
    localparam int WIDTH = 32;
    localparam int NREGS = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_writeback_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    reg_writeback #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  num;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        hold;
        logic        av;
        logic [1:0]  an;
        logic [31:0] ad;
        logic        mv;
        logic [1:0]  mn;
        logic [31:0] md;
        logic [1:0]  qn;
        logic        e_ar;
        logic        e_mr;
        logic        e_wr;
        logic [1:0]  e_wnum;
        logic [31:0] e_wdata;
        logic [3:0]  e_pend;
        logic        e_idle;
        logic        e_qhit;
        logic [31:0] e_qdata;
    } vec_t;

    ent_t        mq[$];
    logic        m_write;
    logic [1:0]  m_wnum;
    logic [31:0] m_wdata;
    logic [31:0] last_val [NREGS];
    logic [31:0] dut_rf   [NREGS];
    vec_t        vt       [11];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic av, input logic [1:0] an, input logic [31:0] ad,
                         input logic mv, input logic [1:0] mn, input logic [31:0] md, input logic [1:0] qn);
        bus.hold      = h;
        bus.alu_valid = av;
        bus.alu_num   = an;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_num   = mn;
        bus.mem_data  = md;
        bus.qnum      = qn;
    endtask

    task automatic model_reset();
        mq.delete();
        m_write = 1'b0;
        m_wnum  = '0;
        m_wdata = '0;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Expected outputs straight from the queue contents and the issue stage.
    task automatic check_model(input string tag);
        int          sz;
        logic [3:0]  pend;
        logic        hit;
        logic [31:0] qd;
        sz   = mq.size();
        pend = '0;
        foreach (mq[i]) pend[mq[i].num] = 1'b1;
        if (m_write) pend[m_wnum] = 1'b1;
        pend[0] = 1'b0;
        hit = 1'b0;
        qd  = '0;
        if (bus.qnum != 0) begin
            for (int i = sz - 1; i >= 0; i--) begin
                if (!hit && mq[i].num == bus.qnum) begin
                    hit = 1'b1;
                    qd  = mq[i].data;
                end
            end
            if (!hit && m_write && m_wnum == bus.qnum) begin
                hit = 1'b1;
                qd  = m_wdata;
            end
        end
        chk({tag, "_mem_ready"}, bus.mem_ready, sz < DEPTH);
        chk({tag, "_alu_ready"}, bus.alu_ready, (sz < DEPTH) && !bus.mem_valid);
        chk({tag, "_write"},     bus.write,     m_write);
        chk({tag, "_wnum"},      bus.wnum,      m_wnum);
        chk({tag, "_wdata"},     bus.wdata,     m_wdata);
        chk({tag, "_pending"},   bus.pending,   pend);
        chk({tag, "_idle"},      bus.idle,      (sz == 0) && !m_write);
        chk({tag, "_qhit"},      bus.qhit,      hit);
        chk({tag, "_qdata"},     bus.qdata,     qd);
    endtask

    task automatic model_step();
        int   sz;
        logic acc;
        ent_t e;
        ent_t h;
        sz  = mq.size();
        acc = 1'b0;
        e   = '{num: 2'd0, data: 32'd0};
        if (bus.mem_valid && sz < DEPTH) begin
            acc = 1'b1;
            e   = '{num: bus.mem_num, data: bus.mem_data};
        end else if (bus.alu_valid && sz < DEPTH) begin
            acc = 1'b1;
            e   = '{num: bus.alu_num, data: bus.alu_data};
        end
        if (!bus.hold && sz > 0) begin
            h       = mq.pop_front();
            m_write = 1'b1;
            m_wnum  = h.num;
            m_wdata = h.data;
        end else begin
            m_write = 1'b0;
        end
        if (acc && e.num != 0) begin
            mq.push_back(e);
            last_val[e.num] = e.data;
        end
    endtask

    // One clock: drive, compare against the model, advance model and DUT.
    task automatic cycle(input string tag, input logic h, input logic av, input logic [1:0] an,
                         input logic [31:0] ad, input logic mv, input logic [1:0] mn,
                         input logic [31:0] md, input logic [1:0] qn);
        drive(h, av, an, ad, mv, mn, md, qn);
        #1;
        check_model(tag);
        if (bus.write) dut_rf[bus.wnum] = bus.wdata;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] t3_exp [6];
        //          hold av an ad            mv mn md        qn  ar mr wr wn wdata         pend  idle hit qdata
        vt[0]  = '{0, 1, 2, 32'hDEADBEEF, 0, 0, 32'h0,   2,  1, 1, 0, 0, 32'h0,        4'h0, 1, 0, 32'h0};
        vt[1]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   2,  1, 1, 0, 0, 32'h0,        4'h4, 0, 1, 32'hDEADBEEF};
        vt[2]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   2,  1, 1, 1, 2, 32'hDEADBEEF, 4'h4, 0, 1, 32'hDEADBEEF};
        vt[3]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   2,  1, 1, 0, 2, 32'hDEADBEEF, 4'h0, 1, 0, 32'h0};
        vt[4]  = '{0, 1, 1, 32'h1,        1, 3, 32'h3,   1,  0, 1, 0, 2, 32'hDEADBEEF, 4'h0, 1, 0, 32'h0};
        vt[5]  = '{0, 1, 1, 32'h1,        0, 0, 32'h0,   3,  1, 1, 0, 2, 32'hDEADBEEF, 4'h8, 0, 1, 32'h3};
        vt[6]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   1,  1, 1, 1, 3, 32'h3,        4'hA, 0, 1, 32'h1};
        vt[7]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   3,  1, 1, 1, 1, 32'h1,        4'h2, 0, 0, 32'h0};
        vt[8]  = '{0, 0, 0, 32'h0,        1, 0, 32'h55,  0,  0, 1, 0, 1, 32'h1,        4'h0, 1, 0, 32'h0};
        vt[9]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   0,  1, 1, 0, 1, 32'h1,        4'h0, 1, 0, 32'h0};
        vt[10] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   0,  1, 1, 0, 1, 32'h1,        4'h0, 1, 0, 32'h0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_write",   bus.write,   1'b0);
        chk("reset_wnum",    bus.wnum,    2'd0);
        chk("reset_wdata",   bus.wdata,   32'd0);
        chk("reset_pending", bus.pending, 4'd0);
        chk("reset_idle",    bus.idle,    1'b1);
        do_reset();

        // Table: single write latency, mem-over-alu priority, r0 drop.
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].hold, vt[i].av, vt[i].an, vt[i].ad, vt[i].mv, vt[i].mn, vt[i].md, vt[i].qn);
            #1;
            chk($sformatf("vec%0d_alu_ready", i), bus.alu_ready, vt[i].e_ar);
            chk($sformatf("vec%0d_mem_ready", i), bus.mem_ready, vt[i].e_mr);
            chk($sformatf("vec%0d_write", i),     bus.write,     vt[i].e_wr);
            chk($sformatf("vec%0d_wnum", i),      bus.wnum,      vt[i].e_wnum);
            chk($sformatf("vec%0d_wdata", i),     bus.wdata,     vt[i].e_wdata);
            chk($sformatf("vec%0d_pending", i),   bus.pending,   vt[i].e_pend);
            chk($sformatf("vec%0d_idle", i),      bus.idle,      vt[i].e_idle);
            chk($sformatf("vec%0d_qhit", i),      bus.qhit,      vt[i].e_qhit);
            chk($sformatf("vec%0d_qdata", i),     bus.qdata,     vt[i].e_qdata);
            @(posedge clk);
            #1;
        end

        // Fill under hold, back-pressure, drain in order, wrap the pointers.
        do_reset();
        t3_exp = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        cycle("t3_push0", 1, 1, 1, 32'h11, 0, 0, 0, 0);
        cycle("t3_push1", 1, 1, 2, 32'h22, 0, 0, 0, 0);
        cycle("t3_push2", 1, 0, 0, 32'h0,  1, 3, 32'h33, 0);
        cycle("t3_push3", 1, 1, 1, 32'h44, 0, 0, 0, 0);
        drive(1, 1, 2, 32'h99, 1, 3, 32'h98, 0);
        #1;
        chk("t3_full_mem_ready", bus.mem_ready, 1'b0);
        chk("t3_full_alu_ready", bus.alu_ready, 1'b0);
        chk("t3_full_write",     bus.write,     1'b0);
        cycle("t3_full", 1, 1, 2, 32'h99, 1, 3, 32'h98, 0);
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("t3_drain%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("t3_order%0d_write", i), bus.write, 1'b1);
            chk($sformatf("t3_order%0d_wdata", i), bus.wdata, t3_exp[i]);
        end
        cycle("t3_wrap0", 0, 1, 2, 32'h55, 0, 0, 0, 0);
        cycle("t3_wrap1", 0, 1, 3, 32'h66, 0, 0, 0, 0);
        chk("t3_wrap_first", bus.wdata, t3_exp[4]);
        cycle("t3_wrap2", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_wrap_second", bus.wdata, t3_exp[5]);
        cycle("t3_wrap3", 0, 0, 0, 0, 0, 0, 0, 0);

        // Two writes to one register: youngest forwarded, pending until last retires.
        do_reset();
        cycle("t5_push0", 1, 1, 2, 32'h5, 0, 0, 0, 2);
        cycle("t5_push1", 1, 1, 2, 32'h7, 0, 0, 0, 2);
        chk("t5_qhit",  bus.qhit,  1'b1);
        chk("t5_qdata", bus.qdata, 32'h7);
        cycle("t5_rel", 0, 0, 0, 0, 0, 0, 0, 2);
        chk("t5_first_wdata",  bus.wdata,   32'h5);
        chk("t5_first_pend",   bus.pending, 4'h4);
        cycle("t5_w1", 0, 0, 0, 0, 0, 0, 0, 2);
        chk("t5_second_wdata", bus.wdata,   32'h7);
        chk("t5_second_pend",  bus.pending, 4'h4);
        cycle("t5_w2", 0, 0, 0, 0, 0, 0, 0, 2);
        chk("t5_after_pend", bus.pending, 4'h0);

        // Reset mid-operation while a write is issuing.
        do_reset();
        cycle("t6_push0", 1, 1, 1, 32'hA1, 0, 0, 0, 0);
        cycle("t6_push1", 1, 1, 2, 32'hA2, 0, 0, 0, 0);
        cycle("t6_push2", 1, 1, 3, 32'hA3, 0, 0, 0, 0);
        cycle("t6_issue", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_pre_write", bus.write, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_write",   bus.write,   1'b0);
        chk("t6_rst_pending", bus.pending, 4'h0);
        chk("t6_rst_idle",    bus.idle,    1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle("t6_new", 0, 1, 3, 32'hABC, 0, 0, 0, 0);
        cycle("t6_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_new_write", bus.write, 1'b1);
        chk("t6_new_wnum",  bus.wnum,  2'd3);
        chk("t6_new_wdata", bus.wdata, 32'hABC);

        // Random traffic against the model; final file contents must hold the
        // last accepted value per register.
        do_reset();
        for (int i = 0; i < NREGS; i++) begin
            last_val[i] = '0;
            dut_rf[i]   = '0;
        end
        for (int i = 0; i < 600; i++) begin
            cycle("rnd", $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom,
                  2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 8; i++) cycle("rnd_drain", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rnd_idle", bus.idle, 1'b1);
        for (int i = 1; i < NREGS; i++) chk($sformatf("rnd_rf%0d", i), dut_rf[i], last_val[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
